// File: rtl/eedc_pkg.sv
// Shared constants and syndrome helper for the Hamming(11,7) decoder.
// Latency: none (declarations only). Backpressure: not applicable.
// Bit index i of a codeword holds Hamming position i+1.
package eedc_pkg;

  localparam int DATA_W = 7;
  localparam int CODE_W = 11;
  localparam int SYN_W  = 4;

  // Hamming position of data bit d[k]
  localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11};

  localparam logic [SYN_W-1:0] SYN_NONE       = 4'd0;
  localparam logic [SYN_W-1:0] SYN_MAX_CORR   = 4'd11;
  localparam logic [SYN_W-1:0] SYN_UNCORR_MIN = 4'd12;

  function automatic logic [SYN_W-1:0] eedc_syndrome(input logic [CODE_W-1:0] cw);
    logic [SYN_W-1:0] s;
    s = '0;
    for (int p = 1; p <= CODE_W; p++) begin
      for (int j = 0; j < SYN_W; j++) begin
        if (p[j]) s[j] = s[j] ^ cw[p-1];
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/eedc_correct.sv
// Single-error correction and data extraction from a codeword and its syndrome.
// Latency: combinational.
// Backpressure: none; purely a function of its inputs.
module eedc_correct
  import eedc_pkg::*;
(
  input  logic [CODE_W-1:0] codeword,
  input  logic [SYN_W-1:0]  syndrome,
  output logic [DATA_W-1:0] data,
  output logic              corrected,
  output logic              uncorrectable
);

  logic [CODE_W-1:0] fixed;

  always_comb begin
    fixed         = codeword;
    corrected     = 1'b0;
    uncorrectable = 1'b0;
    data          = '0;
    if (syndrome != SYN_NONE && syndrome <= SYN_MAX_CORR) begin
      // Syndrome value names the flipped position; parity hits leave data intact.
      for (int p = 1; p <= CODE_W; p++) begin
        if (syndrome == SYN_W'(p)) fixed[p-1] = ~codeword[p-1];
      end
      corrected = 1'b1;
    end else if (syndrome >= SYN_UNCORR_MIN) begin
      uncorrectable = 1'b1;
    end
    for (int k = 0; k < DATA_W; k++) begin
      data[k] = fixed[DATA_POS[k]-1];
    end
  end

endmodule

// File: rtl/eedc_decoder.sv
// Two-stage Hamming(11,7) decoder with saturating error statistics.
// Latency: 2 cycles input-to-output, one word per cycle sustained.
// Backpressure: out_valid & ~out_ready freezes both stages; an empty stage 1 may still fill.
module eedc_decoder
  import eedc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] codeword_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [SYN_W-1:0]  syndrome_out,
  output logic              err_corrected,
  output logic              err_uncorrectable,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  corrected_cnt,
  output logic [CNT_W-1:0]  uncorrectable_cnt
);

  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  logic [SYN_W-1:0]  s1_syn;
  logic              stall;
  logic              out_fire;
  logic [DATA_W-1:0] fix_data;
  logic              fix_corr;
  logic              fix_unc;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall | ~s1_valid;
  assign out_fire = out_valid & out_ready;

  eedc_correct u_correct (
    .codeword      (s1_code),
    .syndrome      (s1_syn),
    .data          (fix_data),
    .corrected     (fix_corr),
    .uncorrectable (fix_unc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= codeword_in;
        s1_syn  <= eedc_syndrome(codeword_in);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid         <= 1'b0;
      data_out          <= '0;
      syndrome_out      <= '0;
      err_corrected     <= 1'b0;
      err_uncorrectable <= 1'b0;
    end else if (!stall) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out          <= fix_data;
        syndrome_out      <= s1_syn;
        err_corrected     <= fix_corr;
        err_uncorrectable <= fix_unc;
      end
    end
  end

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corrected_cnt     <= '0;
      uncorrectable_cnt <= '0;
    end else if (cnt_clear) begin
      corrected_cnt     <= '0;
      uncorrectable_cnt <= '0;
    end else begin
      if (out_fire && err_corrected && !(&corrected_cnt))
        corrected_cnt <= corrected_cnt + CNT_W'(1);
      if (out_fire && err_uncorrectable && !(&uncorrectable_cnt))
        uncorrectable_cnt <= uncorrectable_cnt + CNT_W'(1);
    end
  end

endmodule
